// File: rtl/alu_result_streamer.sv
// alu_result_streamer: buffers 16-bit ALU results in a FIFO and streams them as bytes (LO, HI).
// Define RESULT_TAG_HDR_EN to prefix each entry with a {4'hA, tag} header byte.
module alu_result_streamer #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic [3:0]       in_tag,
  input  logic             out_ready,
  input  logic             clr_ovf,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
`ifdef RESULT_TAG_HDR_EN
  localparam int unsigned EntryW = 20;
`else
  localparam int unsigned EntryW = 16;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi
`ifdef RESULT_TAG_HDR_EN
    ,
    StHdr
`endif
  } state_e;

`ifdef RESULT_TAG_HDR_EN
  localparam state_e StFirst = StHdr;
`else
  localparam state_e StFirst = StLo;
`endif

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [EntryW-1:0] wr_entry;
  logic [EntryW-1:0] entry_q, entry_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  state_e            state_q, state_d;
  logic              push, pop, drop;

`ifdef RESULT_TAG_HDR_EN
  assign wr_entry = {in_tag, in_data};
`else
  assign wr_entry = in_data;
  // Tag is only carried when the header feature is built in.
  logic unused_tag;
  assign unused_tag = ^in_tag;
`endif

  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = overflow_q;

  // Full is sampled before the edge, so a pop on the same edge never frees room for a push.
  assign push = in_valid & ~full;
  assign drop = in_valid & full;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
    overflow_d = overflow_q;
    entry_d    = entry_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      entry_d  = mem_q[rd_ptr_q];
    end
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    out_valid = 1'b0;
    out_byte  = '0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StFirst;
        end
      end
`ifdef RESULT_TAG_HDR_EN
      StHdr: begin
        out_valid = 1'b1;
        out_byte  = {4'hA, entry_q[19:16]};
        if (out_ready) begin
          state_d = StLo;
        end
      end
`endif
      StLo: begin
        out_valid = 1'b1;
        out_byte  = entry_q[7:0];
        if (out_ready) begin
          state_d = StHi;
        end
      end
      StHi: begin
        out_valid = 1'b1;
        out_byte  = entry_q[15:8];
        if (out_ready) begin
          // Chain straight into the next entry to avoid an idle bubble.
          if (!empty) begin
            pop     = 1'b1;
            state_d = StFirst;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      entry_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      entry_q    <= entry_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_alu_result_streamer.sv
// Scoreboard bench for alu_result_streamer: expected bytes queued at push, checked on transfer.
module tb_alu_result_streamer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
`ifdef RESULT_TAG_HDR_EN
  localparam int BPE = 3;
`else
  localparam int BPE = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [15:0]      in_data = '0;
  logic [3:0]       in_tag = '0;
  logic             out_ready = 1'b0;
  logic             clr_ovf = 1'b0;
  logic [7:0]       out_byte;
  logic             out_valid;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;
  logic             overflow;

  int         n_checks = 0;
  int         n_bad = 0;
  logic [7:0] sb [$];
  logic [7:0] exp_b;

  alu_result_streamer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_ready (out_ready),
    .clr_ovf   (clr_ovf),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_entry(input logic [15:0] d, input logic [3:0] t);
`ifdef RESULT_TAG_HDR_EN
    sb.push_back({4'hA, t});
`endif
    sb.push_back(d[7:0]);
    sb.push_back(d[15:8]);
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] t, input bit accept);
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    if (accept) expect_entry(d, t);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && (sb.size() != 0 || out_valid); i++) step();
    check({tag, "_sb_left"}, sb.size(), 0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_empty"}, empty, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_valid", out_valid, 1'b0);
      end else begin
        exp_b = sb.pop_front();
        check("byte", out_byte, exp_b);
      end
    end
  end

  initial begin
    logic [7:0] first_b;
    int         cnt;

    // Reset state
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_byte", out_byte, 8'h00);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // Single entry, latency of one edge after the push
    out_ready = 1'b1;
    push(16'h1234, 4'h0, 1'b1);
    check("lat_push_edge", out_valid, 1'b0);
    step();
    check("lat_next_edge", out_valid, 1'b1);
    drain("single");

    // Backpressure: head byte held stable for 5 stalled cycles
    out_ready = 1'b0;
`ifdef RESULT_TAG_HDR_EN
    first_b = 8'hA0;
`else
    first_b = 8'hEF;
`endif
    push(16'hBEEF, 4'h0, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_byte", out_byte, first_b);
      step();
    end
    out_ready = 1'b1;
    drain("bp");

    // Fill and overflow. Entry 1 moves into the serializer, so the FIFO fills on the 9th push.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(16'(i), 4'(i), 1'b1);
    check("fill8_level", level, 7);
    check("fill8_full", full, 1'b0);
    push(16'h0009, 4'h9, 1'b1);
    check("fill9_level", level, 8);
    check("fill9_full", full, 1'b1);
    check("fill9_ovf", overflow, 1'b0);
    push(16'h000A, 4'hA, 1'b0);
    check("drop_ovf", overflow, 1'b1);
    check("drop_level", level, 8);
    clr_ovf = 1'b1;
    push(16'h000E, 4'hE, 1'b0);
    check("drop_beats_clr", overflow, 1'b1);
    step();
    clr_ovf = 1'b0;
    check("clr_ovf", overflow, 1'b0);

    // Release and push 3 more across the pointer wrap
    out_ready = 1'b1;
    for (int i = 0; i < 40 && level > 5; i++) step();
    check("room_for_3", level <= 5, 1'b1);
    push(16'h000B, 4'hB, 1'b1);
    push(16'h000C, 4'hC, 1'b1);
    push(16'h000D, 4'hD, 1'b1);
    drain("wrap");

    // Same-edge push/pop keeps level; back-to-back entries with no bubble
    push(16'h0A0B, 4'h1, 1'b1);
    check("lvl_first_push", level, 1);
    push(16'h0C0D, 4'h2, 1'b1);
    check("lvl_push_pop", level, 1);
    cnt = 0;
    for (int i = 0; i < 20 && out_valid; i++) begin
      cnt++;
      step();
    end
    check("b2b_valid_cycles", cnt, 2 * BPE);
    drain("b2b");

    // Tagged entry
    push(16'h5566, 4'h3, 1'b1);
    drain("tag");

    // Reset asserted mid-cycle while the LO byte is presented
    out_ready = 1'b0;
    push(16'h7788, 4'h5, 1'b1);
    step();
`ifdef RESULT_TAG_HDR_EN
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`endif
    check("lo_before_rst", out_byte, 8'h88);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_byte", out_byte, 8'h00);
    check("mid_rst_level", level, 0);
    check("mid_rst_empty", empty, 1'b1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) step();
    check("no_replay_valid", out_valid, 1'b0);
    check("no_replay_empty", empty, 1'b1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
